clkctrl_speed_fsm: RTL and testbench

//   Drives the select inputs of the clock switcher that multiplexes the CPU clock between
//   the host (low-speed) and local (high-speed) sources.

---
 rtl/clkctrl_speed_fsm.sv | 139 +++++++++++++
 tb/tb_clkctrl_speed_fsm.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/clkctrl_speed_fsm.sv
// Sequences CPU clock changeovers between the host (slow) and local (fast) sources.
// Decodes each CPU cycle, holds the turbo control register and drives the clock switcher selects.
module clkctrl_speed_fsm #(
  parameter logic [15:0] FAST_TOP    = 16'h8000,
  parameter logic [15:0] CTRL_ADDR   = 16'hFE4F,
  parameter int unsigned SLOW_HOLD   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic [15:0] addr_in,
  input  logic        vda_in,
  input  logic        vpa_in,
  input  logic        rnw_in,
  input  logic [7:0]  data_in,
  input  logic        hsclk_selected,
  input  logic        lsclk_selected,
  output logic        hsclk_sel,
  output logic [1:0]  cpuclk_div_sel,
  output logic        fast_mode,
  output logic [7:0]  data_out,
  output logic        data_oe
);

  localparam int unsigned HOLD_W = 4;
  localparam int unsigned CTRL_W = 3;

  typedef enum logic [1:0] {
    SLOW    = 2'b00,
    TO_FAST = 2'b01,
    FAST    = 2'b10,
    TO_SLOW = 2'b11
  } state_t;

  state_t                  state_q;
  logic [CTRL_W-1:0]       ctrl_q;
  logic [HOLD_W-1:0]       hold_cnt;
  logic [SYNC_STAGES-1:0]  hs_sync;
  logic [SYNC_STAGES-1:0]  ls_sync;

  logic valid;
  logic host;
  logic wr;
  logic turbo_en;
  logic hs_ack;
  logic ls_ack;
  logic unused_data;

  // Cycle decode for the current CPU cycle
  assign valid    = vda_in | vpa_in;
  assign host     = valid & (addr_in >= FAST_TOP);
  assign wr       = vda_in & ~rnw_in & (addr_in == CTRL_ADDR);
  assign data_oe  = vda_in & rnw_in & (addr_in == CTRL_ADDR);
  assign turbo_en = ctrl_q[0];
  assign hs_ack   = hs_sync[SYNC_STAGES-1];
  assign ls_ack   = ls_sync[SYNC_STAGES-1];

  assign data_out    = {state_q, 3'b000, ctrl_q};
  // Upper write-data bits have no storage behind them
  assign unused_data = ^data_in[7:CTRL_W];

  // Selected-flag synchronisers; the switcher flags are asynchronous to clk_in
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      hs_sync <= '0;
      ls_sync <= '0;
    end else begin
      hs_sync <= {hs_sync[SYNC_STAGES-2:0], hsclk_selected};
      ls_sync <= {ls_sync[SYNC_STAGES-2:0], lsclk_selected};
    end
  end

  // Turbo control register and the applied divider copy (only refreshed while on the slow clock)
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      ctrl_q         <= '0;
      cpuclk_div_sel <= '0;
    end else begin
      if (wr) begin
        ctrl_q <= data_in[CTRL_W-1:0];
      end
      if (state_q == SLOW) begin
        cpuclk_div_sel <= ctrl_q[2:1];
      end
    end
  end

  // Speed FSM; decisions use the pre-write turbo_en of this cycle
  always_ff @(negedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= SLOW;
      hsclk_sel <= 1'b0;
      fast_mode <= 1'b0;
      hold_cnt  <= HOLD_W'(SLOW_HOLD);
    end else begin
      case (state_q)
        SLOW: begin
          if (host) begin
            hold_cnt <= HOLD_W'(SLOW_HOLD);
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
          if (turbo_en && (hold_cnt == '0) && !host) begin
            state_q   <= TO_FAST;
            hsclk_sel <= 1'b1;
          end
        end
        TO_FAST: begin
          if (!turbo_en || host) begin
            state_q   <= TO_SLOW;
            hsclk_sel <= 1'b0;
          end else if (hs_ack) begin
            state_q   <= FAST;
            fast_mode <= 1'b1;
          end
        end
        FAST: begin
          if (host || !turbo_en) begin
            state_q   <= TO_SLOW;
            hsclk_sel <= 1'b0;
            fast_mode <= 1'b0;
          end
        end
        TO_SLOW: begin
          if (ls_ack) begin
            state_q  <= SLOW;
            hold_cnt <= HOLD_W'(SLOW_HOLD);
          end
        end
        default: begin
          state_q   <= SLOW;
          hsclk_sel <= 1'b0;
          fast_mode <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clkctrl_speed_fsm.sv
// Directed bench for clkctrl_speed_fsm: driver queues hand-computed per-cycle results,
// a monitor compares them half a clock after each falling edge.
module tb_clkctrl_speed_fsm;

  localparam logic [1:0] SL = 2'b00;
  localparam logic [1:0] TF = 2'b01;
  localparam logic [1:0] FA = 2'b10;
  localparam logic [1:0] TS = 2'b11;

  logic        clk_in;
  logic        rst;
  logic [15:0] addr_in;
  logic        vda_in;
  logic        vpa_in;
  logic        rnw_in;
  logic [7:0]  data_in;
  logic        hsclk_selected;
  logic        lsclk_selected;
  logic        hsclk_sel;
  logic [1:0]  cpuclk_div_sel;
  logic        fast_mode;
  logic [7:0]  data_out;
  logic        data_oe;

  typedef struct packed {
    int unsigned id;
    logic [7:0]  dout;
    logic        hs;
    logic        fast;
    logic [1:0]  div;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc_id   = 0;
  logic nxt_hs;
  logic nxt_ls;

  clkctrl_speed_fsm dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .addr_in        (addr_in),
    .vda_in         (vda_in),
    .vpa_in         (vpa_in),
    .rnw_in         (rnw_in),
    .data_in        (data_in),
    .hsclk_selected (hsclk_selected),
    .lsclk_selected (lsclk_selected),
    .hsclk_sel      (hsclk_sel),
    .cpuclk_div_sel (cpuclk_div_sel),
    .fast_mode      (fast_mode),
    .data_out       (data_out),
    .data_oe        (data_oe)
  );

  initial clk_in = 1'b1;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, id, act, exp);
    end
  endtask

  // One CPU cycle: drive mid-cycle, queue what the DUT must show after the falling edge
  task automatic cyc(input logic [15:0] a, input logic vda, input logic vpa, input logic rnw,
                     input logic [7:0] d, input logic [1:0] est, input logic [2:0] ectrl,
                     input logic ehs, input logic efast, input logic [1:0] ediv);
    exp_t e;
    @(posedge clk_in);
    #1;
    cyc_id++;
    addr_in = a; vda_in = vda; vpa_in = vpa; rnw_in = rnw; data_in = d;
    hsclk_selected = nxt_hs;
    lsclk_selected = nxt_ls;
    e.id   = cyc_id;
    e.dout = {est, 3'b000, ectrl};
    e.hs   = ehs;
    e.fast = efast;
    e.div  = ediv;
    q.push_back(e);
    #1;
    chk("data_oe", cyc_id, 8'(data_oe), 8'(vda & rnw & (a == 16'hFE4F)));
  endtask

  task automatic loc(input logic [1:0] est, input logic [2:0] ectrl, input logic ehs,
                     input logic efast, input logic [1:0] ediv);
    cyc(16'h1000, 1'b0, 1'b1, 1'b1, 8'h00, est, ectrl, ehs, efast, ediv);
  endtask

  task automatic hst(input logic [1:0] est, input logic [2:0] ectrl, input logic ehs,
                     input logic efast, input logic [1:0] ediv);
    cyc(16'hC000, 1'b1, 1'b0, 1'b1, 8'h00, est, ectrl, ehs, efast, ediv);
  endtask

  task automatic wrc(input logic [7:0] d, input logic [1:0] est, input logic [2:0] ectrl,
                     input logic ehs, input logic efast, input logic [1:0] ediv);
    cyc(16'hFE4F, 1'b1, 1'b0, 1'b0, d, est, ectrl, ehs, efast, ediv);
  endtask

  task automatic rdc(input logic [7:0] erd, input logic [1:0] est, input logic [2:0] ectrl,
                     input logic ehs, input logic efast, input logic [1:0] ediv);
    cyc(16'hFE4F, 1'b1, 1'b0, 1'b1, 8'h00, est, ectrl, ehs, efast, ediv);
    chk("rd_data", cyc_id, data_out, erd);
  endtask

  // Monitor: compare queued expectations on the rising edge, away from the active falling edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("data_out", int'(e.id), data_out, e.dout);
        chk("hsclk_sel", int'(e.id), 8'(hsclk_sel), 8'(e.hs));
        chk("fast_mode", int'(e.id), 8'(fast_mode), 8'(e.fast));
        chk("div_sel", int'(e.id), 8'(cpuclk_div_sel), 8'(e.div));
      end
    end
  end

  initial begin
    rst = 1'b1;
    addr_in = 16'h0000; vda_in = 1'b0; vpa_in = 1'b0; rnw_in = 1'b1; data_in = 8'h00;
    nxt_hs = 1'b0; nxt_ls = 1'b1;
    hsclk_selected = 1'b0; lsclk_selected = 1'b1;
    #2;
    chk("rst_data_out", 0, data_out, 8'h00);
    chk("rst_hsclk_sel", 0, 8'(hsclk_sel), 8'h00);
    chk("rst_fast_mode", 0, 8'(fast_mode), 8'h00);
    chk("rst_div_sel", 0, 8'(cpuclk_div_sel), 8'h00);
    @(posedge clk_in);
    #2 rst = 1'b0;

    // Turbo on; write cycle is host-region so the hold count reloads first
    wrc(8'h01, SL, 3'b001, 1'b0, 1'b0, 2'b00);
    repeat (4) loc(SL, 3'b001, 1'b0, 1'b0, 2'b00);
    loc(TF, 3'b001, 1'b1, 1'b0, 2'b00);
    nxt_hs = 1'b1; nxt_ls = 1'b0;
    repeat (2) loc(TF, 3'b001, 1'b1, 1'b0, 2'b00);
    loc(FA, 3'b001, 1'b1, 1'b1, 2'b00);

    // Host read while fast, then LS acknowledge through the synchroniser
    hst(TS, 3'b001, 1'b0, 1'b0, 2'b00);
    nxt_hs = 1'b0; nxt_ls = 1'b1;
    repeat (2) loc(TS, 3'b001, 1'b0, 1'b0, 2'b00);
    loc(SL, 3'b001, 1'b0, 1'b0, 2'b00);

    // Host access at hold_cnt==1 reloads the hold-off
    repeat (3) loc(SL, 3'b001, 1'b0, 1'b0, 2'b00);
    hst(SL, 3'b001, 1'b0, 1'b0, 2'b00);
    repeat (4) loc(SL, 3'b001, 1'b0, 1'b0, 2'b00);
    loc(TF, 3'b001, 1'b1, 1'b0, 2'b00);
    nxt_hs = 1'b1; nxt_ls = 1'b0;
    repeat (2) loc(TF, 3'b001, 1'b1, 1'b0, 2'b00);
    loc(FA, 3'b001, 1'b1, 1'b1, 2'b00);

    // Divider request written while fast is applied only once back in SLOW
    wrc(8'h07, TS, 3'b111, 1'b0, 1'b0, 2'b00);
    nxt_hs = 1'b0; nxt_ls = 1'b1;
    rdc(8'hC7, TS, 3'b111, 1'b0, 1'b0, 2'b00);
    loc(TS, 3'b111, 1'b0, 1'b0, 2'b00);
    loc(SL, 3'b111, 1'b0, 1'b0, 2'b00);
    loc(SL, 3'b111, 1'b0, 1'b0, 2'b11);
    repeat (3) loc(SL, 3'b111, 1'b0, 1'b0, 2'b11);
    loc(TF, 3'b111, 1'b1, 1'b0, 2'b11);
    nxt_hs = 1'b1; nxt_ls = 1'b0;
    repeat (2) loc(TF, 3'b111, 1'b1, 1'b0, 2'b11);
    loc(FA, 3'b111, 1'b1, 1'b1, 2'b11);

    // Turbo cleared by a host-region write: a single TO_SLOW, no re-entry to TO_FAST
    wrc(8'h00, TS, 3'b000, 1'b0, 1'b0, 2'b11);
    nxt_hs = 1'b0; nxt_ls = 1'b1;
    repeat (2) loc(TS, 3'b000, 1'b0, 1'b0, 2'b11);
    loc(SL, 3'b000, 1'b0, 1'b0, 2'b11);
    repeat (6) loc(SL, 3'b000, 1'b0, 1'b0, 2'b00);

    // Reach TO_FAST again, then reset asynchronously mid-changeover
    wrc(8'h01, SL, 3'b001, 1'b0, 1'b0, 2'b00);
    repeat (4) loc(SL, 3'b001, 1'b0, 1'b0, 2'b00);
    loc(TF, 3'b001, 1'b1, 1'b0, 2'b00);
    @(posedge clk_in);
    #2 rst = 1'b1;
    #1;
    chk("arst_data_out", cyc_id, data_out, 8'h00);
    chk("arst_hsclk_sel", cyc_id, 8'(hsclk_sel), 8'h00);
    chk("arst_fast_mode", cyc_id, 8'(fast_mode), 8'h00);
    #1 rst = 1'b0;
    repeat (2) loc(SL, 3'b000, 1'b0, 1'b0, 2'b00);

    repeat (3) @(posedge clk_in);
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
